fu_input_join: RTL and testbench
================================

// Module: FU_input_join
// PURPOSE
//  Elastic front end of one CGRA functional unit, placed directly upstream of the FU data path.
//  - Buffers the din_1, din_2 and cin valid/ready channels.
//  - Joins the channels enabled by configuration and issues a one-cycle en_o to the data path.
//  - Tracks output validity toward downstream consumers of dout.
// PARAMETERS
//  DATA_WIDTH  32  width of din_1/din_2 channels and data-path operands
//  DEPTH       2   entries per input buffer; power of 2, >=2
//  CNT_WIDTH   32  width of the performance counters (optional feature only)
// PORTS
//  clk_i          in   1           clock
//  rst_ni         in   1           asynchronous reset, active low
//  clr_i          in   1           synchronous clear: empty all buffers, drop dout_v_o
//  din_1_used_i   in   1           config: channel din_1 takes part in the join
//  din_2_used_i   in   1           config: channel din_2 takes part in the join
//  cin_used_i     in   1           config: channel cin takes part in the join
//  init_valid_i   in   1           config: dout is valid after the initial load
//  din_1_i        in   DATA_WIDTH  upstream data, channel 1
//  din_1_v_i      in   1           channel 1 valid
//  din_1_r_o      out  1           channel 1 ready
//  din_2_i / din_2_v_i / din_2_r_o  idem, channel 2
//  cin_i / cin_v_i / cin_r_o        idem, 1-bit control channel
//  din_1_o        out  DATA_WIDTH  head of channel-1 buffer, to data path
//  din_2_o        out  DATA_WIDTH  head of channel-2 buffer, to data path
//  cin_o          out  1           head of cin buffer, to data path
//  en_o           out  1           data-path register enable (fire)
//  dout_v_o       out  1           data-path output holds an unconsumed result
//  dout_r_i       in   1           downstream accepts dout this cycle
// BEHAVIOUR
//  Reset:
//  - All buffers empty; en_o=0; dout_v_o=0; *_r_o=1 (full deasserted).
//  - Counters 0.
//  Buffers:
//  - Push when v_i & r_o; r_o = !full (no same-cycle pass-through when full).
//  - Pushed data appears on *_o the cycle after the push (latency 1).
//  - Simultaneous push and pop when not full: count unchanged.
//  - Pointers wrap modulo DEPTH.
//  Unused channels (*_used_i=0):
//  - r_o=1 permanently; incoming data is discarded.
//  - *_o shows the buffer head, undefined content.
//  Fire:
//  - fire = AND(!empty for every used channel) & (!dout_v_o | dout_r_i).
//  - If no channel is used, fire is gated by the output condition only.
//  - en_o = fire (combinational, same cycle).
//  - fire pops every used buffer in that cycle.
//  dout_v_o:
//  - Set on fire.
//  - Else cleared on dout_r_i.
//  - Fire and dout_r_i in the same cycle: stays 1 (new result replaces consumed one).
//  Initial load:
//  - The data path loads its initial value in the first clock after reset.
//  - In that same cycle, dout_v_o <= init_valid_i.
//  - en_o is forced 0 for that cycle.
//  clr_i:
//  - Same effect as reset except the initial-load cycle is not repeated.
//  - clr_i has priority over fire and push.
//  Reset asserted mid-transfer: all in-flight buffered tokens are lost; no recovery.
// CONFIGURATION
//  FU_JOIN_PERF_EN: compiled in when defined, out otherwise.
//  - Defined:
//    - Adds outputs fire_cnt_o[CNT_WIDTH] and stall_cnt_o[CNT_WIDTH].
//    - fire_cnt_o counts fire cycles.
//    - stall_cnt_o counts cycles with all used inputs available but dout_v_o & !dout_r_i.
//    - Both saturate at all-ones and are cleared by clr_i.
//  - Undefined: ports and logic are absent.
// STRUCTURE
//  Shared package fu_pkg:
//  - typedef fu_join_cfg_t {din_1_used, din_2_used, cin_used, init_valid}.
//  - localparam DEFAULT_BUF_DEPTH = 2.
//  Sub-module FU_elastic_buffer #(WIDTH, DEPTH):
//  - Circular FIFO with count, full, empty.
//  - Instantiated three times (cin with WIDTH=1).
// TESTING
//  1. Reset, all channels used, init_valid_i=1 -> cycle 1: en_o=0, dout_v_o=1; *_r_o=1.
//  2. din_1=5, din_2=7, cin=1 pushed together, dout_r_i=1 -> next cycle: din_1_o=5, din_2_o=7, cin_o=1, en_o=1; buffers empty after.
//  3. dout_r_i=0 with dout_v_o=1, push 3 tokens on din_1 -> two accepted, din_1_r_o=0 after 2nd; en_o=0 throughout.
//  4. Only din_1 used; stream 1,2,3 with dout_r_i=1 -> en_o on 3 consecutive cycles; din_2/cin ignored, ready=1.
//  5. Same cycle fire and dout_r_i=1 with dout_v_o=1 -> dout_v_o stays 1, one pop per used buffer.
//  6. clr_i with 2 tokens buffered -> next cycle: all empty, dout_v_o=0, counters 0 (FU_JOIN_PERF_EN defined).

Source files
------------

// File: rtl/fu_pkg.sv
// fu_pkg: shared configuration types and defaults for the CGRA functional-unit front end.
package fu_pkg;
   typedef struct packed {
      logic din_1_used;
      logic din_2_used;
      logic cin_used;
      logic init_valid;
   } fu_join_cfg_t;
   localparam int DEFAULT_BUF_DEPTH = 2;
endpackage

// File: rtl/fu_elastic_buffer.sv
// fu_elastic_buffer: circular FIFO with full/empty flags and synchronous clear.
module fu_elastic_buffer
   import fu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = DEFAULT_BUF_DEPTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] cnt_q;
   logic do_push, do_pop;
   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i & !full_o;
   assign do_pop  = pop_i & !empty_o;
   assign data_o  = mem_q[rd_q];
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   // Storage needs no reset: entries are only observed once pushed.
   always_ff @(posedge clk_i)
      if (do_push && !clr_i) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/fu_input_join.sv
// fu_input_join: buffers din_1/din_2/cin, joins the configured channels into en_o, tracks dout validity.
// Defining FU_JOIN_PERF_EN adds saturating fire_cnt_o/stall_cnt_o counters.
module fu_input_join
   import fu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = DEFAULT_BUF_DEPTH
`ifdef FU_JOIN_PERF_EN
   , parameter int CNT_WIDTH = 32
`endif
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  din_1_used_i,
   input  logic                  din_2_used_i,
   input  logic                  cin_used_i,
   input  logic                  init_valid_i,
   input  logic [DATA_WIDTH-1:0] din_1_i,
   input  logic                  din_1_v_i,
   output logic                  din_1_r_o,
   input  logic [DATA_WIDTH-1:0] din_2_i,
   input  logic                  din_2_v_i,
   output logic                  din_2_r_o,
   input  logic                  cin_i,
   input  logic                  cin_v_i,
   output logic                  cin_r_o,
   output logic [DATA_WIDTH-1:0] din_1_o,
   output logic [DATA_WIDTH-1:0] din_2_o,
   output logic                  cin_o,
   output logic                  en_o,
   output logic                  dout_v_o,
`ifdef FU_JOIN_PERF_EN
   output logic [CNT_WIDTH-1:0]  fire_cnt_o,
   output logic [CNT_WIDTH-1:0]  stall_cnt_o,
`endif
   input  logic                  dout_r_i
);
   fu_join_cfg_t cfg;
   logic [2:0] used, valid, empty, full, push, pop;
   logic init_q, dout_v_q, avail, fire;
   assign cfg = '{din_1_used: din_1_used_i, din_2_used: din_2_used_i,
                  cin_used: cin_used_i, init_valid: init_valid_i};
   assign used  = {cfg.cin_used, cfg.din_2_used, cfg.din_1_used};
   assign valid = {cin_v_i, din_2_v_i, din_1_v_i};
   assign push  = valid & used & ~full;
   assign pop   = {3{fire}} & used;
   assign avail = &(~used | ~empty);
   // The initial-load cycle belongs to the data path, so no fire then.
   assign fire  = avail & (!dout_v_q | dout_r_i) & !init_q & !clr_i;
   assign en_o      = fire;
   assign dout_v_o  = dout_v_q;
   assign din_1_r_o = !used[0] | !full[0];
   assign din_2_r_o = !used[1] | !full[1];
   assign cin_r_o   = !used[2] | !full[2];
   fu_elastic_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_din_1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .push_i(push[0]), .pop_i(pop[0]),
      .data_i(din_1_i), .data_o(din_1_o), .full_o(full[0]), .empty_o(empty[0]));
   fu_elastic_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_din_2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .push_i(push[1]), .pop_i(pop[1]),
      .data_i(din_2_i), .data_o(din_2_o), .full_o(full[1]), .empty_o(empty[1]));
   fu_elastic_buffer #(.WIDTH(1), .DEPTH(DEPTH)) u_cin (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .push_i(push[2]), .pop_i(pop[2]),
      .data_i(cin_i), .data_o(cin_o), .full_o(full[2]), .empty_o(empty[2]));
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         init_q   <= 1'b1;
         dout_v_q <= 1'b0;
      end else begin
         init_q   <= 1'b0;
         dout_v_q <= clr_i ? 1'b0 : init_q ? cfg.init_valid : fire ? 1'b1 : dout_r_i ? 1'b0 : dout_v_q;
      end
`ifdef FU_JOIN_PERF_EN
   logic stall;
   assign stall = avail & dout_v_q & !dout_r_i;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         fire_cnt_o  <= '0;
         stall_cnt_o <= '0;
      end else if (clr_i) begin
         fire_cnt_o  <= '0;
         stall_cnt_o <= '0;
      end else begin
         if (fire && !(&fire_cnt_o)) fire_cnt_o <= fire_cnt_o + 1'b1;
         if (stall && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
      end
`endif
endmodule

// File: tb/tb_fu_input_join.sv
// tb_fu_input_join: directed and randomized checks of fu_input_join against a queue-based model.
module tb_fu_input_join;
   localparam int DW = 32;
   localparam int DEPTH = 2;
   logic clk_i = 1'b0, rst_ni = 1'b0, clr_i = 1'b0;
   logic din_1_used_i = 1'b1, din_2_used_i = 1'b1, cin_used_i = 1'b1, init_valid_i = 1'b1;
   logic [DW-1:0] din_1_i = '0, din_2_i = '0;
   logic cin_i = 1'b0, din_1_v_i = 1'b0, din_2_v_i = 1'b0, cin_v_i = 1'b0, dout_r_i = 1'b0;
   logic din_1_r_o, din_2_r_o, cin_r_o, cin_o, en_o, dout_v_o;
   logic [DW-1:0] din_1_o, din_2_o;
`ifdef FU_JOIN_PERF_EN
   logic [31:0] fire_cnt_o, stall_cnt_o;
`endif
   int vectors = 0, miscompares = 0, en_seen = 0;
   logic [DW-1:0] q1[$], q2[$];
   logic qc[$];
   bit m_dv, m_first;
   longint m_fc, m_sc;

   always #5 clk_i = ~clk_i;

   fu_input_join #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
      .din_1_used_i(din_1_used_i), .din_2_used_i(din_2_used_i), .cin_used_i(cin_used_i),
      .init_valid_i(init_valid_i),
      .din_1_i(din_1_i), .din_1_v_i(din_1_v_i), .din_1_r_o(din_1_r_o),
      .din_2_i(din_2_i), .din_2_v_i(din_2_v_i), .din_2_r_o(din_2_r_o),
      .cin_i(cin_i), .cin_v_i(cin_v_i), .cin_r_o(cin_r_o),
      .din_1_o(din_1_o), .din_2_o(din_2_o), .cin_o(cin_o),
      .en_o(en_o), .dout_v_o(dout_v_o),
`ifdef FU_JOIN_PERF_EN
      .fire_cnt_o(fire_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
      .dout_r_i(dout_r_i));

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_avail();
      return (!din_1_used_i || q1.size() > 0) && (!din_2_used_i || q2.size() > 0) &&
             (!cin_used_i || qc.size() > 0);
   endfunction

   function automatic bit m_fire();
      return !m_first && !clr_i && m_avail() && (!m_dv || dout_r_i);
   endfunction

   task automatic m_reset();
      q1.delete(); q2.delete(); qc.delete();
      m_dv = 0; m_first = 1; m_fc = 0; m_sc = 0;
   endtask

   task automatic compare();
      chk("en_o", en_o, m_fire());
      chk("dout_v_o", dout_v_o, m_dv);
      chk("din_1_r_o", din_1_r_o, !din_1_used_i || q1.size() < DEPTH);
      chk("din_2_r_o", din_2_r_o, !din_2_used_i || q2.size() < DEPTH);
      chk("cin_r_o", cin_r_o, !cin_used_i || qc.size() < DEPTH);
      if (din_1_used_i && q1.size() > 0) chk("din_1_o", din_1_o, q1[0]);
      if (din_2_used_i && q2.size() > 0) chk("din_2_o", din_2_o, q2[0]);
      if (cin_used_i && qc.size() > 0) chk("cin_o", cin_o, qc[0]);
`ifdef FU_JOIN_PERF_EN
      chk("fire_cnt_o", fire_cnt_o, m_fc[31:0]);
      chk("stall_cnt_o", stall_cnt_o, m_sc[31:0]);
`endif
      en_seen += int'(en_o);
   endtask

   task automatic update();
      bit f, p1, p2, pc, st;
      f  = m_fire();
      p1 = din_1_v_i && din_1_used_i && q1.size() < DEPTH;
      p2 = din_2_v_i && din_2_used_i && q2.size() < DEPTH;
      pc = cin_v_i && cin_used_i && qc.size() < DEPTH;
      st = m_avail() && m_dv && !dout_r_i;
      if (clr_i) begin
         q1.delete(); q2.delete(); qc.delete();
         m_dv = 0; m_fc = 0; m_sc = 0;
      end else begin
         if (f && din_1_used_i) q1.delete(0);
         if (f && din_2_used_i) q2.delete(0);
         if (f && cin_used_i) qc.delete(0);
         if (p1) q1.push_back(din_1_i);
         if (p2) q2.push_back(din_2_i);
         if (pc) qc.push_back(cin_i);
         m_dv = m_first ? init_valid_i : f ? 1'b1 : dout_r_i ? 1'b0 : m_dv;
         if (f && m_fc < 64'hffffffff) m_fc++;
         if (st && m_sc < 64'hffffffff) m_sc++;
      end
      m_first = 0;
   endtask

   task automatic step();
      @(negedge clk_i);
      compare();
      @(posedge clk_i);
      update();
      #1;
   endtask

   task automatic set_v(input logic [2:0] v);
      {cin_v_i, din_2_v_i, din_1_v_i} = v;
   endtask

   initial begin
      m_reset();
      repeat (3) @(posedge clk_i);
      chk("rst_r1", din_1_r_o, 1); chk("rst_r2", din_2_r_o, 1); chk("rst_rc", cin_r_o, 1);
      chk("rst_en", en_o, 0); chk("rst_dv", dout_v_o, 0);
      #1 rst_ni = 1'b1;
      step();
      chk("t1_dv", dout_v_o, 1); chk("t1_en", en_o, 0);
      dout_r_i = 1; din_1_i = 5; din_2_i = 7; cin_i = 1; set_v(3'b111);
      step();
      set_v(3'b000); #1;
      chk("t2_d1", din_1_o, 5); chk("t2_d2", din_2_o, 7); chk("t2_c", cin_o, 1); chk("t2_en", en_o, 1);
      step();
      chk("t2_empty_en", en_o, 0); chk("t2_dv", dout_v_o, 1);
      dout_r_i = 0;
      for (int i = 0; i < 3; i++) begin
         din_1_i = DW'(10 + i); set_v(3'b001);
         step();
         if (i == 1) chk("t3_r1_full", din_1_r_o, 0);
      end
      set_v(3'b000);
      chk("t3_head", din_1_o, 10);
      clr_i = 1;
      step();
      clr_i = 0; #1;
      chk("t6_r1", din_1_r_o, 1); chk("t6_dv", dout_v_o, 0); chk("t6_en", en_o, 0);
`ifdef FU_JOIN_PERF_EN
      chk("t6_fcnt", fire_cnt_o, 0); chk("t6_scnt", stall_cnt_o, 0);
`endif
      din_2_used_i = 0; cin_used_i = 0; dout_r_i = 1; en_seen = 0;
      for (int i = 1; i <= 3; i++) begin
         din_1_i = DW'(i); din_2_i = $urandom; cin_i = 1'($urandom); set_v(3'b111); #1;
         chk("t4_r2", din_2_r_o, 1); chk("t4_rc", cin_r_o, 1);
         step();
      end
      set_v(3'b000);
      step(); step();
      chk("t4_en_cycles", en_seen, 3);
      din_2_used_i = 1; cin_used_i = 1; dout_r_i = 0;
      din_1_i = 100; din_2_i = 200; cin_i = 1; set_v(3'b111);
      step();
      din_1_i = 101; din_2_i = 201; cin_i = 0;
      step();
      set_v(3'b000);
      step();
      dout_r_i = 1; #1;
      chk("t5_en", en_o, 1); chk("t5_head", din_1_o, 101);
      step();
      chk("t5_dv", dout_v_o, 1); chk("t5_en_after", en_o, 0);
      din_1_i = 55; din_2_i = 66; set_v(3'b111);
      step();
      set_v(3'b000);
      rst_ni = 0; #1;
      chk("mrst_r1", din_1_r_o, 1); chk("mrst_dv", dout_v_o, 0); chk("mrst_en", en_o, 0);
      m_reset();
      init_valid_i = 0;
      @(posedge clk_i); #1 rst_ni = 1;
      step();
      chk("mrst_init_dv", dout_v_o, 0);
      for (int b = 0; b < 24; b++) begin
         {cin_used_i, din_2_used_i, din_1_used_i} = 3'($urandom);
         clr_i = 1;
         step();
         clr_i = 0;
         for (int c = 0; c < 60; c++) begin
            din_1_i = $urandom; din_2_i = $urandom; cin_i = 1'($urandom);
            din_1_v_i = $urandom_range(3) != 0;
            din_2_v_i = $urandom_range(3) != 0;
            cin_v_i   = $urandom_range(3) != 0;
            dout_r_i  = $urandom_range(1) == 1;
            clr_i     = $urandom_range(49) == 0;
            step();
         end
         clr_i = 0;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
